// File: rtl/cfi_alarm_unit_pkg.sv
// cfi_alarm_unit_pkg: shared types for the CFI alarm unit.
// Holds the commit-port shape the unit observes, the alarm FSM state and
// the cause encoding reported to the exception/debug logic.
package cfi_alarm_unit_pkg;

    // Virtual address width of committed PCs.
    localparam int unsigned VLEN = 64;

    // Number of commit ports fed in parallel from the commit stage.
    localparam int unsigned NR_COMMIT_PORTS = 2;

    // Slice of a scoreboard entry; only the PC is consumed by the alarm unit.
    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic [2:0]      trans_id;
        logic            valid;
    } scoreboard_entry_t;

    // Alarm FSM: IDLE waits for a violation event, ALARM holds it until acked.
    typedef enum logic {
        IDLE  = 1'b0,
        ALARM = 1'b1
    } cfi_alarm_state_e;

    // Cause bits: bit0 JALR/return violation, bit1 JAL/call violation.
    typedef struct packed {
        logic call;
        logic ret;
    } cfi_cause_t;

endpackage

// File: rtl/cfi_pc_log.sv
// cfi_pc_log: plain synchronous FIFO of alarm PCs.
// A pop on empty is ignored. A push on full is dropped and raises a sticky
// overflow flag, unless a pop frees the slot in the same cycle.
module cfi_pc_log
    import cfi_alarm_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 64
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    input  logic         clr_ovf_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         ovf_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         r_ovf;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Extra pointer MSB distinguishes full from empty.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = pop_i & ~w_empty;
    assign w_push  = push_i & (~w_full | w_pop);
    assign w_drop  = push_i & w_full & ~w_pop;

    // Storage array; contents only matter behind valid pointers.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= data_i;
        end
    end

    // Read/write pointers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Sticky overflow; clear wins over a same-cycle drop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ovf <= 1'b0;
        end else if (clr_ovf_i) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    assign valid_o = ~w_empty;
    assign data_o  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign ovf_o   = r_ovf;

endmodule

// File: rtl/cfi_alarm_unit.sv
// cfi_alarm_unit: converts level CFI violation flags into one alarm per
// violation, captures the last committed PC, counts violation events and
// requests a commit halt while an alarm is pending.
// Optional PC log FIFO enabled by defining CFI_ALARM_PC_LOG_EN.
//
// Alarm handshake: alarm_req_o stays high from the capturing edge until the
// clock edge that samples alarm_ack_i=1; it drops after that edge unless a
// new violation event arrives on the same edge, which re-arms the alarm.
module cfi_alarm_unit
    import cfi_alarm_unit_pkg::*;
#(
    parameter int unsigned CNT_W        = 8,
    parameter bit          HALT_ON_VIOL = 1'b1,
    parameter int unsigned LOG_DEPTH    = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  scoreboard_entry_t [NR_COMMIT_PORTS-1:0] commit_instr_i,
    input  logic [NR_COMMIT_PORTS-1:0]            commit_ack_i,
    input  logic [1:0]                            flow_integrity_violated_i,
    input  logic                                  available_i,
    input  logic                                  alarm_ack_i,
    input  logic                                  clear_i,
    output logic                                  alarm_req_o,
    output logic [1:0]                            alarm_cause_o,
    output logic [VLEN-1:0]                       alarm_pc_o,
    output logic                                  halt_commit_o,
    output logic [CNT_W-1:0]                      viol_count_o,
    output logic                                  alarm_ovf_o,
    output logic                                  log_valid_o,
    output logic [VLEN-1:0]                       log_pc_o,
    input  logic                                  log_pop_i,
    output logic                                  log_ovf_o
);

    cfi_alarm_state_e r_state;
    cfi_alarm_state_e w_state_next;

    logic [VLEN-1:0]  r_last_pc;
    logic [VLEN-1:0]  w_next_last_pc;
    logic [1:0]       r_viol_q;
    logic [1:0]       w_viol_now;
    logic [1:0]       w_ev;
    logic             w_any_ev;
    cfi_cause_t       r_cause;
    logic [VLEN-1:0]  r_alarm_pc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_count;
    logic             w_capture;
    logic             w_accum;
    logic             w_release;
    logic             w_unused_commit;

    // Highest-index acked port wins when several commit together.
    always_comb begin
        w_next_last_pc = r_last_pc;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (commit_ack_i[i]) begin
                w_next_last_pc = commit_instr_i[i].pc;
            end
        end
    end

    // Only the PC of each commit port is observed.
    always_comb begin
        w_unused_commit = 1'b0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            w_unused_commit = w_unused_commit ^
                (^{commit_instr_i[i].trans_id, commit_instr_i[i].valid});
        end
    end

    // Last committed PC register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last_pc <= '0;
        end else begin
            r_last_pc <= w_next_last_pc;
        end
    end

    // Flags are masked while the checker is disarmed; an event is a rising edge.
    assign w_viol_now = flow_integrity_violated_i & {2{available_i}};
    assign w_ev       = w_viol_now & ~r_viol_q;
    assign w_any_ev   = |w_ev;

    // Previous masked flag level for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_viol_q <= '0;
        end else begin
            r_viol_q <= w_viol_now;
        end
    end

    // Alarm FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus capture/accumulate/release strobes.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_accum      = 1'b0;
        w_release    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any_ev) begin
                    w_state_next = ALARM;
                    w_capture    = 1'b1;
                end
            end
            ALARM: begin
                if (alarm_ack_i) begin
                    if (w_any_ev) begin
                        // Ack and new event together start a fresh alarm.
                        w_state_next = ALARM;
                        w_capture    = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                        w_release    = 1'b1;
                    end
                end else if (w_any_ev) begin
                    w_accum = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Cause and PC of the pending alarm; PC is only taken on entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cause    <= '0;
            r_alarm_pc <= '0;
        end else if (w_capture) begin
            r_cause    <= w_ev;
            r_alarm_pc <= r_last_pc;
        end else if (w_accum) begin
            r_cause    <= r_cause | w_ev;
        end else if (w_release) begin
            r_cause    <= '0;
        end
    end

    // Sticky alarm overflow; clear has priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ovf <= 1'b0;
        end else if (clear_i) begin
            r_ovf <= 1'b0;
        end else if (w_accum) begin
            r_ovf <= 1'b1;
        end
    end

    // Saturating event counter; one increment per cycle with any event.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= '0;
        end else if (w_any_ev && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign alarm_req_o   = (r_state == ALARM);
    assign alarm_cause_o = r_cause;
    assign alarm_pc_o    = r_alarm_pc;
    assign halt_commit_o = HALT_ON_VIOL && (r_state == ALARM);
    assign viol_count_o  = r_count;
    assign alarm_ovf_o   = r_ovf;

`ifdef CFI_ALARM_PC_LOG_EN
    logic w_unused_log;
    assign w_unused_log = w_unused_commit;

    cfi_pc_log #(
        .DEPTH (LOG_DEPTH),
        .W     (VLEN)
    ) u_pc_log (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (w_capture),
        .data_i    (r_last_pc),
        .pop_i     (log_pop_i),
        .clr_ovf_i (clear_i),
        .valid_o   (log_valid_o),
        .data_o    (log_pc_o),
        .ovf_o     (log_ovf_o)
    );
`else
    logic w_unused_log;
    assign w_unused_log = w_unused_commit ^ log_pop_i ^ LOG_DEPTH[0];

    assign log_valid_o = 1'b0;
    assign log_pc_o    = '0;
    assign log_ovf_o   = 1'b0;
`endif

endmodule
